// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the 4-bit state encoding.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_DATA   = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX_DATA   = 4'd5,
    ST_TX_ACK    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line conditioner: 2-FF synchronizer, FILTER_LEN-sample glitch filter,
// and 1-cycle rise/fall strobes aligned with the filtered level change.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_in,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic             take_d;

  // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
  assign take_d = (sync2_q != level_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));

  // Two-flop synchronizer; idle bus level is high.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

  // Glitch filter and edge strobes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= take_d & sync2_q;
      fall_q <= take_d & ~sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (take_d) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: filtered SCL/SDA, START/STOP detection, fixed 7-bit address
// match, byte receive/transmit with host handshakes, open-drain SDA only.
//
// state     | meaning
// IDLE      | bus free or disabled, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving address ACK
// RX_DATA   | shifting in a write byte
// RX_ACK    | ACK/NACK of a received byte, delivers it to the host
// TX_DATA   | driving a read byte MSB first
// TX_ACK    | sampling the master's ACK after a read byte
// WAIT_STOP | released, ignoring the bus until START/STOP
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h42,
  parameter int                    FILTER_LEN = 3,
  parameter int                    T_HD_CYC   = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable_in,
  input  logic [BYTE_W-1:0] tx_data_in,
  input  logic              rx_ready_in,
  output logic [BYTE_W-1:0] rx_data_out,
  output logic              rx_valid_out,
  output logic              tx_load_out,
  output logic              addressed_out,
  output logic              rd_wr_out,
  output logic [3:0]        value_state,
  inout  wire               SCL,
  inout  wire               SDA
);

  localparam int HOLD_W = $clog2(T_HD_CYC + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d, tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d, byte_in;
  logic              rx_valid_q, rx_valid_d, tx_load_q, tx_load_d;
  logic              addressed_q, addressed_d, rd_wr_q, rd_wr_d;
  logic              sda_oe_q, sda_oe_d, oe_pend_q, oe_pend_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_in(clk_in), .rst(rst), .line_i(SCL),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_in(clk_in), .rst(rst), .line_i(SDA),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift_q[BYTE_W-2:0], sda_lvl};

  // State and datapath registers; reset releases SDA asynchronously.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      addressed_q <= 1'b0;
      rd_wr_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      oe_pend_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      addressed_q <= addressed_d;
      rd_wr_q     <= rd_wr_d;
      sda_oe_q    <= sda_oe_d;
      oe_pend_q   <= oe_pend_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next state: bus conditions first, then per-state bit handling.
  // Every SCL fall schedules the next SDA drive value through the hold timer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    addressed_d = addressed_q;
    rd_wr_d     = rd_wr_q;
    sda_oe_d    = sda_oe_q;
    oe_pend_d   = oe_pend_q;
    hold_cnt_d  = hold_cnt_q;

    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
      if (hold_cnt_q == HOLD_W'(1)) sda_oe_d = oe_pend_q;
    end

    if (!enable_in || stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      hold_cnt_d  = '0;
      addressed_d = 1'b0;
    end else if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      hold_cnt_d  = '0;
      addressed_d = 1'b0;
    end else begin
      if (scl_fall) begin
        hold_cnt_d = HOLD_W'(T_HD_CYC);
        oe_pend_d  = 1'b0;
      end
      case (state_q)
        ST_ADDR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_RX_DATA) begin
                state_d = ST_RX_ACK;
              end else if (byte_in[BYTE_W-1:1] == SLAVE_ADDR) begin
                state_d     = ST_ADDR_ACK;
                rd_wr_d     = byte_in[0];
                addressed_d = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) oe_pend_d = 1'b1;
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (rd_wr_q) begin
              tx_shift_d = tx_data_in;
              tx_load_d  = 1'b1;
              state_d    = ST_TX_DATA;
            end else begin
              state_d = ST_RX_DATA;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (rx_ready_in) begin
              oe_pend_d = 1'b1;
            end else begin
              state_d     = ST_WAIT_STOP;
              addressed_d = 1'b0;
            end
          end
          if (scl_rise) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_RX_DATA;
          end
        end
        ST_TX_DATA: begin
          if (scl_rise) begin
            if (sda_lvl != tx_shift_q[BYTE_W-1]) begin
              state_d     = ST_WAIT_STOP;
              sda_oe_d    = 1'b0;
              hold_cnt_d  = '0;
              addressed_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_TX_ACK;
              bit_cnt_d = '0;
            end else begin
              oe_pend_d = ~tx_shift_q[BYTE_W-1];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              tx_shift_d = tx_data_in;
              tx_load_d  = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_TX_DATA;
            end else begin
              state_d     = ST_WAIT_STOP;
              addressed_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA           = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data_out   = rx_data_q;
  assign rx_valid_out  = rx_valid_q;
  assign tx_load_out   = tx_load_q;
  assign addressed_out = addressed_q;
  assign rd_wr_out     = rd_wr_q;
  assign value_state   = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench for i2c_slave acting as a bus master model.
module tb_i2c_slave;

  localparam logic [6:0] SLAVE = 7'h42;
  localparam int Q = 16;
  localparam int S_IDLE = 0, S_RX_DATA = 3, S_WAIT_STOP = 7;

  logic       clk_in = 1'b0;
  logic       rst, enable_in, rx_ready_in;
  logic [7:0] tx_data_in, rx_data_out;
  logic       rx_valid_out, tx_load_out, addressed_out, rd_wr_out;
  logic [3:0] value_state;
  wire        SCL, SDA;
  logic       scl_m, sda_m;

  int         checks = 0, failures = 0;
  int         rx_cnt = 0, tx_loads = 0, tx_base = 0;
  logic [7:0] rx_log [64];
  logic [7:0] tx_mem [16];
  logic [7:0] wbuf [8];
  bit         both_seen = 1'b0;

  always #5 clk_in = ~clk_in;

  pullup (SCL);
  pullup (SDA);
  assign SCL = scl_m ? 1'bz : 1'b0;
  assign SDA = sda_m ? 1'bz : 1'b0;
  assign tx_data_in = tx_mem[4'(tx_loads - tx_base)];

  i2c_slave dut (
    .clk_in(clk_in), .rst(rst), .enable_in(enable_in),
    .tx_data_in(tx_data_in), .rx_ready_in(rx_ready_in),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
    .tx_load_out(tx_load_out), .addressed_out(addressed_out),
    .rd_wr_out(rd_wr_out), .value_state(value_state),
    .SCL(SCL), .SDA(SDA)
  );

  // Host side: log delivered bytes, advance the read source on each load.
  always @(negedge clk_in) begin
    if (rx_valid_out) begin
      rx_log[rx_cnt % 64] = rx_data_out;
      rx_cnt++;
    end
    if (tx_load_out) tx_loads++;
    if (rx_valid_out && tx_load_out) both_seen = 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check(input string grp, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", grp, name, obs, exp);
    end
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic s);
    wait_cyc(Q); sda_m = b;
    wait_cyc(Q); scl_m = 1'b1;
    if (glitch) begin
      wait_cyc(Q / 2); scl_m = 1'b0;
      wait_cyc(1);     scl_m = 1'b1;
      wait_cyc(Q / 2 - 1);
    end else begin
      wait_cyc(Q);
    end
    s = SDA;
    wait_cyc(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      wait_cyc(Q); sda_m = 1'b1;
      wait_cyc(Q); scl_m = 1'b1;
    end
    wait_cyc(Q); sda_m = 1'b0;
    wait_cyc(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(Q); sda_m = 1'b0;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(Q); sda_m = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic ack_bit);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], i == glitch_at, s);
    clock_bit(1'b1, 1'b0, ack_bit);
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(master_ack ? 1'b0 : 1'b1, 1'b0, s);
  endtask

  // Write transaction of wbuf[0..n-1]; model: address ACK iff match, each
  // byte ACKed and delivered while addressed and the host is ready.
  task automatic run_write(input string tag, input logic [6:0] addr, input int n, input logic ready);
    logic       a;
    int         base;
    bit         alive;
    logic [7:0] expq [$];
    base = rx_cnt;
    rx_ready_in = ready;
    i2c_start();
    write_byte({addr, 1'b0}, -1, a);
    alive = (addr == SLAVE);
    check(tag, "addr_ack", a, alive ? 0 : 1);
    if (alive) check(tag, "addressed", addressed_out, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], -1, a);
      alive = alive && ready;
      check(tag, "data_ack", a, alive ? 0 : 1);
      if (alive) expq.push_back(wbuf[i]);
    end
    check(tag, "state_pre_stop", value_state, alive ? S_RX_DATA : S_WAIT_STOP);
    i2c_stop();
    wait_cyc(8);
    check(tag, "rx_count", rx_cnt - base, expq.size());
    foreach (expq[i]) check(tag, "rx_data", rx_log[(base + i) % 64], expq[i]);
    check(tag, "state_idle", value_state, S_IDLE);
    check(tag, "addressed_clr", addressed_out, 0);
    rx_ready_in = 1'b1;
  endtask

  // Read transaction of n bytes from tx_mem; master ACKs all but the last.
  task automatic run_read(input string tag, input logic [6:0] addr, input int n);
    logic       a;
    logic [7:0] d;
    bit         alive;
    tx_base = tx_loads;
    i2c_start();
    write_byte({addr, 1'b1}, -1, a);
    alive = (addr == SLAVE);
    check(tag, "addr_ack", a, alive ? 0 : 1);
    if (alive) begin
      check(tag, "rd_wr", rd_wr_out, 1);
      check(tag, "load_at_addr", tx_loads - tx_base, 1);
    end
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      check(tag, "rd_byte", d, alive ? tx_mem[i] : 8'hFF);
    end
    check(tag, "tx_loads", tx_loads - tx_base, alive ? n : 0);
    check(tag, "state_after_nack", value_state, S_WAIT_STOP);
    check(tag, "sda_released", SDA, 1);
    i2c_stop();
    wait_cyc(8);
    check(tag, "state_idle", value_state, S_IDLE);
    check(tag, "addressed_clr", addressed_out, 0);
  endtask

  initial begin
    logic       a, s;
    logic [7:0] d;
    logic [6:0] ra;
    int         base, n;

    rst = 1'b1; enable_in = 1'b1; rx_ready_in = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
    wait_cyc(5);
    check("reset", "state", value_state, S_IDLE);
    check("reset", "rx_data", rx_data_out, 0);
    check("reset", "rx_valid", rx_valid_out, 0);
    check("reset", "tx_load", tx_load_out, 0);
    check("reset", "addressed", addressed_out, 0);
    check("reset", "rd_wr", rd_wr_out, 0);
    check("reset", "sda", SDA, 1);
    rst = 1'b0;
    wait_cyc(10);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    run_write("wr_a5_3c", SLAVE, 2, 1'b1);

    tx_mem[0] = 8'h5A; tx_mem[1] = 8'hC3; tx_mem[2] = 8'($urandom);
    run_read("rd_5a_c3", SLAVE, 2);

    wbuf[0] = 8'($urandom);
    run_write("wr_addr43", 7'h43, 1, 1'b1);

    wbuf[0] = 8'h11;
    run_write("wr_not_ready", SLAVE, 1, 1'b0);

    // Write then repeated START into a read.
    base = rx_cnt;
    i2c_start();
    write_byte(8'h84, -1, a);
    check("rstart", "addr_ack_w", a, 0);
    write_byte(8'h01, -1, a);
    check("rstart", "data_ack", a, 0);
    check("rstart", "rd_wr_before", rd_wr_out, 0);
    tx_mem[0] = 8'($urandom);
    tx_base = tx_loads;
    i2c_start();
    write_byte(8'h85, -1, a);
    check("rstart", "addr_ack_r", a, 0);
    check("rstart", "rd_wr_after", rd_wr_out, 1);
    check("rstart", "load_at_addr", tx_loads - tx_base, 1);
    read_byte(1'b0, d);
    check("rstart", "rd_byte", d, tx_mem[0]);
    i2c_stop();
    wait_cyc(8);
    check("rstart", "rx_count", rx_cnt - base, 1);
    check("rstart", "rx_data", rx_log[base % 64], 8'h01);
    check("rstart", "state_idle", value_state, S_IDLE);

    // 1-cycle SCL glitch inside a data bit.
    base = rx_cnt;
    i2c_start();
    write_byte(8'h84, -1, a);
    check("glitch", "addr_ack", a, 0);
    write_byte(8'h96, 3, a);
    check("glitch", "data_ack", a, 0);
    i2c_stop();
    wait_cyc(8);
    check("glitch", "rx_count", rx_cnt - base, 1);
    check("glitch", "rx_data", rx_log[base % 64], 8'h96);

    // Asynchronous reset while the target drives SDA low mid-byte.
    tx_mem[0] = 8'h00; tx_mem[1] = 8'h00;
    tx_base = tx_loads;
    i2c_start();
    write_byte(8'h85, -1, a);
    check("rst_mid", "addr_ack", a, 0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0, s);
    check("rst_mid", "sda_driven", SDA, 0);
    base = rx_cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_mid", "sda_released", SDA, 1);
    check("rst_mid", "state", value_state, S_IDLE);
    check("rst_mid", "addressed", addressed_out, 0);
    check("rst_mid", "tx_load", tx_load_out, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_cyc(10);
    rst = 1'b0;
    wait_cyc(10);
    check("rst_mid", "no_rx", rx_cnt - base, 0);
    check("rst_mid", "state_after", value_state, S_IDLE);

    // Randomized transactions.
    for (int k = 0; k < 4; k++) begin
      ra = 7'($urandom_range(0, 127));
      if (ra == SLAVE) ra = 7'h43;
      if ($urandom_range(0, 3) != 0) ra = SLAVE;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      run_write("rnd_wr", ra, n, ($urandom_range(0, 4) != 0));
      n = $urandom_range(1, 3);
      for (int i = 0; i < 16; i++) tx_mem[i] = 8'($urandom);
      run_read("rnd_rd", SLAVE, n);
    end

    check("global", "no_rx_tx_overlap", both_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
